// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative shift-add multiplier / restoring divider feeding HI/LO
// One shared adder serves both the multiply accumulate and the divide trial subtraction.
module mult_div_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [DATA_WIDTH-1:0] operand_a,
    input  logic [DATA_WIDTH-1:0] operand_b,
    output logic                  busy,
    output logic                  result_valid,
    output logic [DATA_WIDTH-1:0] hi_data,
    output logic [DATA_WIDTH-1:0] lo_data
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W);
    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
    state_t         state;
    logic           is_div;
    logic           sign_a;
    logic           sign_b;
    logic [W-1:0]   mag_a;
    logic [W-1:0]   mag_b;
    logic [2*W-1:0] acc;
    logic [CW-1:0]  cnt;
    logic           in_sign_a;
    logic           in_sign_b;
    logic [W-1:0]   in_mag_a;
    logic [W-1:0]   in_mag_b;
    logic [W-1:0]   mul_add;
    logic [W:0]     add_x;
    logic [W+1:0]   add_y;
    logic [W+1:0]   sum;
    logic [W-1:0]   quo;
    logic [W-1:0]   rem;
    logic [W-1:0]   raw_a;
    logic [2*W-1:0] prod;
    logic [W-1:0]   fix_hi;
    logic [W-1:0]   fix_lo;
    // Multiply: acc = {partial, multiplier}; divide: acc = {remainder, dividend/quotient}
    always_comb begin
        in_sign_a = ~op[0] & operand_a[W-1];
        in_sign_b = ~op[0] & operand_b[W-1];
        in_mag_a  = in_sign_a ? -operand_a : operand_a;
        in_mag_b  = in_sign_b ? -operand_b : operand_b;
        mul_add   = acc[0] ? mag_a : '0;
        add_x     = is_div ? acc[2*W-1:W-1] : {1'b0, acc[2*W-1:W]};
        add_y     = is_div ? ~{2'b00, mag_b} : {2'b00, mul_add};
        sum       = {1'b0, add_x} + add_y + (W+2)'(is_div);
        quo       = acc[W-1:0];
        rem       = acc[2*W-1:W];
        raw_a     = sign_a ? -mag_a : mag_a;
        prod      = (sign_a ^ sign_b) ? -acc : acc;
        fix_lo    = !is_div ? prod[W-1:0] : (mag_b == '0) ? '1 : (sign_a ^ sign_b) ? -quo : quo;
        fix_hi    = !is_div ? prod[2*W-1:W] : (mag_b == '0) ? raw_a : sign_a ? -rem : rem;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            hi_data      <= '0;
            lo_data      <= '0;
            cnt          <= '0;
            is_div       <= 1'b0;
            sign_a       <= 1'b0;
            sign_b       <= 1'b0;
            mag_a        <= '0;
            mag_b        <= '0;
            acc          <= '0;
        end else begin
            result_valid <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state  <= RUN;
                    busy   <= 1'b1;
                    is_div <= op[1];
                    sign_a <= in_sign_a;
                    sign_b <= in_sign_b;
                    mag_a  <= in_mag_a;
                    mag_b  <= in_mag_b;
                    acc    <= {{W{1'b0}}, op[1] ? in_mag_a : in_mag_b};
                    cnt    <= '0;
                end
                RUN: begin
                    // a set sum[W+1] means the trial subtraction went negative: restore
                    acc <= !is_div ? {sum[W:0], acc[W-1:1]} :
                           sum[W+1] ? {acc[2*W-2:0], 1'b0} : {sum[W-1:0], acc[W-2:0], 1'b1};
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(W-1)) state <= FIX;
                end
                FIX: begin
                    hi_data      <= fix_hi;
                    lo_data      <= fix_lo;
                    result_valid <= 1'b1;
                    state        <= DONE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: random and directed MULT/MULTU/DIV/DIVU against an arithmetic reference model
module tb_mult_div_unit;
    localparam int W = 32;
    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic [1:0]    op;
    logic [W-1:0]  operand_a;
    logic [W-1:0]  operand_b;
    logic          busy;
    logic          result_valid;
    logic [W-1:0]  hi_data;
    logic [W-1:0]  lo_data;
    int            total = 0;
    int            bad = 0;
    logic [63:0]   last;

    always #5 clock = ~clock;

    mult_div_unit #(.DATA_WIDTH(W)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op),
        .operand_a(operand_a), .operand_b(operand_b), .busy(busy),
        .result_valid(result_valid), .hi_data(hi_data), .lo_data(lo_data)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        int sa;
        int sb;
        sa = a;
        sb = b;
        if (o == 2'd0) return 64'(longint'(sa) * longint'(sb));
        if (o == 2'd1) return {32'd0, a} * {32'd0, b};
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (o == 2'd3) return {a % b, a / b};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        return {32'(sa % sb), 32'(sa / sb)};
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // poke > 0 re-asserts start with junk operands that many edges into the run
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input int poke);
        logic [63:0] exp;
        int k;
        exp = model(o, a, b);
        k = 0;
        op = o;
        operand_a = a;
        operand_b = b;
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        check("busy_start", busy, 1);
        for (int i = 1; i <= W + 4; i++) begin
            if (i == poke) begin
                start = 1'b1;
                op = 2'($urandom);
                operand_a = $urandom;
                operand_b = $urandom;
            end else start = 1'b0;
            @(posedge clock);
            #1;
            if (result_valid) begin
                k = i;
                break;
            end
            check("hold", {hi_data, lo_data}, last);
            check("busy_run", busy, 1);
        end
        start = 1'b0;
        check("latency", k, W + 1);
        check("result", {hi_data, lo_data}, exp);
        check("busy_done", busy, 1);
        last = exp;
        @(posedge clock);
        #1;
        check("pulse_end", result_valid, 0);
        check("busy_idle", busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int seen;
        reset = 1'b1;
        start = 1'b0;
        op = 2'd0;
        operand_a = '0;
        operand_b = '0;
        last = '0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_busy", busy, 0);
        check("rst_valid", result_valid, 0);
        check("rst_hilo", {hi_data, lo_data}, 64'd0);
        reset = 1'b0;
        run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(2'd0, 32'hFFFF_FFFD, 32'd7, 0);
        run_op(2'd0, 32'h7FFF_FFFF, 32'd2, 0);
        run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 0);
        run_op(2'd3, 32'd7, 32'd2, 0);
        run_op(2'd3, 32'd100, 32'd0, 0);
        run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(2'd2, 32'hFFFF_FF9C, 32'd0, 0);
        run_op(2'd1, 32'd6, 32'd7, 5);
        // reset ten edges into a DIV
        op = 2'd2;
        operand_a = 32'h1234_5678;
        operand_b = 32'd3;
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (9) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        check("midrst_busy", busy, 0);
        check("midrst_valid", result_valid, 0);
        check("midrst_hilo", {hi_data, lo_data}, 64'd0);
        last = '0;
        seen = 0;
        repeat (40) begin
            @(posedge clock);
            #1;
            if (result_valid) seen = 1;
        end
        check("midrst_nopulse", seen, 0);
        run_op(2'd1, 32'd2, 32'd3, 0);
        // reset and start on the same edge
        reset = 1'b1;
        start = 1'b1;
        op = 2'd1;
        operand_a = 32'd9;
        operand_b = 32'd9;
        @(posedge clock);
        #1 reset = 1'b0;
        start = 1'b0;
        check("rst_start_busy", busy, 0);
        check("rst_start_hilo", {hi_data, lo_data}, 64'd0);
        last = '0;
        repeat (40) run_op(2'($urandom), pick(), pick(), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 30) : 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
